// File: rtl/vga_console_pkg.sv
// Shared constants, attribute layout and sizing helper for the VGA console
// text renderer.
package vga_console_pkg;

    localparam int unsigned ATTR_FG_LSB  = 8;
    localparam int unsigned ATTR_BG_LSB  = 12;
    localparam logic [3:0]  DEFAULT_FG   = 4'hF;
    localparam logic [3:0]  DEFAULT_BG   = 4'h0;
    localparam int unsigned PIPE_LATENCY = 3;

    typedef struct packed {
        logic [3:0] fg;
        logic [3:0] bg;
    } attr_t;

    // Counter/address width for a range of 'count' values, never narrower than 1 bit.
    function automatic int unsigned addr_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/vga_console_grid_counter.sv
// Character-grid walker: tracks pixel/glyph position and issues the linear,
// unscrolled character RAM address in step with the timing generator.
module vga_console_grid_counter
    import vga_console_pkg::*;
#(
    parameter int unsigned COLS    = 80,
    parameter int unsigned ROWS    = 30,
    parameter int unsigned GLYPH_W = 8,
    parameter int unsigned GLYPH_H = 16,
    localparam int unsigned AW = addr_width(COLS * ROWS),
    localparam int unsigned XW = addr_width(GLYPH_W),
    localparam int unsigned YW = addr_width(GLYPH_H),
    localparam int unsigned CW = $clog2(COLS + 1),
    localparam int unsigned RW = $clog2(ROWS + 1),
    localparam int unsigned BW = $clog2(COLS * ROWS + 1)
) (
    input  logic          vga_clk,
    input  logic          reset_n,
    input  logic          i_vsync,
    input  logic          i_de,
    output logic [XW-1:0] o_glyph_x,
    output logic [YW-1:0] o_glyph_y,
    output logic          o_in_grid,
    output logic [AW-1:0] o_address
);

    logic [XW-1:0] r_glyph_x, w_glyph_x_nxt;
    logic [CW-1:0] r_col, w_col_nxt;
    logic [YW-1:0] r_glyph_y, w_glyph_y_nxt;
    logic [RW-1:0] r_row, w_row_nxt;
    logic [BW-1:0] r_row_base, w_row_base_nxt;
    logic          r_de_d;
    logic [AW-1:0] r_last_addr;
    logic [AW-1:0] w_sum;

    always_comb begin
        w_glyph_x_nxt  = r_glyph_x;
        w_col_nxt      = r_col;
        w_glyph_y_nxt  = r_glyph_y;
        w_row_nxt      = r_row;
        w_row_base_nxt = r_row_base;
        if (i_vsync) begin
            w_glyph_x_nxt  = '0;
            w_col_nxt      = '0;
            w_glyph_y_nxt  = '0;
            w_row_nxt      = '0;
            w_row_base_nxt = '0;
        end else if (i_de) begin
            if (r_glyph_x == XW'(GLYPH_W - 1)) begin
                w_glyph_x_nxt = '0;
                if (r_col != CW'(COLS)) w_col_nxt = r_col + CW'(1);
            end else begin
                w_glyph_x_nxt = r_glyph_x + XW'(1);
            end
        end else if (r_de_d) begin
            // Falling edge of DE: end of a scan line.
            w_glyph_x_nxt = '0;
            w_col_nxt     = '0;
            if (r_glyph_y == YW'(GLYPH_H - 1)) begin
                w_glyph_y_nxt = '0;
                if (r_row != RW'(ROWS)) begin
                    w_row_nxt      = r_row + RW'(1);
                    w_row_base_nxt = r_row_base + BW'(COLS);
                end
            end else begin
                w_glyph_y_nxt = r_glyph_y + YW'(1);
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_glyph_x   <= '0;
            r_col       <= '0;
            r_glyph_y   <= '0;
            r_row       <= '0;
            r_row_base  <= '0;
            r_de_d      <= 1'b0;
            r_last_addr <= '0;
        end else begin
            r_glyph_x  <= w_glyph_x_nxt;
            r_col      <= w_col_nxt;
            r_glyph_y  <= w_glyph_y_nxt;
            r_row      <= w_row_nxt;
            r_row_base <= w_row_base_nxt;
            r_de_d     <= i_de;
            if (o_in_grid) r_last_addr <= w_sum;
        end
    end

    assign w_sum     = AW'(r_row_base) + AW'(r_col);
    assign o_in_grid = (r_col < CW'(COLS)) && (r_row < RW'(ROWS));
    // Off-grid the RAM keeps seeing the last valid cell rather than an out-of-range index.
    assign o_address = o_in_grid ? w_sum : r_last_addr;
    assign o_glyph_x = r_glyph_x;
    assign o_glyph_y = r_glyph_y;

endmodule

// File: rtl/vga_console_text_renderer.sv
// Text-mode pixel pipeline: character fetch, glyph lookup, attributes and
// blinking cursor, with syncs/DE delayed to line up with the colour output.
module vga_console_text_renderer
    import vga_console_pkg::*;
#(
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned GLYPH_W      = 8,
    parameter int unsigned GLYPH_H      = 16,
    parameter int unsigned CHAR_BITS    = 16,
    parameter int unsigned BLINK_FRAMES = 32,
    localparam int unsigned AW = addr_width(COLS * ROWS),
    localparam int unsigned XW = addr_width(GLYPH_W),
    localparam int unsigned YW = addr_width(GLYPH_H),
    localparam int unsigned FW = addr_width(BLINK_FRAMES)
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    input  logic                 in_hsync,
    input  logic                 in_vsync,
    input  logic                 in_de,
    output logic [AW-1:0]        vga_char_address,
    input  logic [CHAR_BITS-1:0] vga_char,
    output logic [8+YW-1:0]      font_address,
    input  logic [GLYPH_W-1:0]   font_row,
    input  logic                 cursor_enable,
    input  logic [AW-1:0]        cursor_address,
    output logic                 out_hsync,
    output logic                 out_vsync,
    output logic                 out_de,
    output logic [3:0]           out_color
);

    if (!(CHAR_BITS == 8 || CHAR_BITS == 16) || GLYPH_W == 0 || GLYPH_W > 32) begin : g_bad_cfg
        $error("vga_console_text_renderer: unsupported CHAR_BITS or GLYPH_W");
    end

    logic [XW-1:0]           w_glyph_x;
    logic [YW-1:0]           w_glyph_y;
    logic                    w_in_grid;
    logic [PIPE_LATENCY-1:0] r_hs_pipe, r_vs_pipe, r_de_pipe;
    logic                    r_grid_d1, r_grid_d2;
    logic [XW-1:0]           r_gx_d1, r_gx_d2;
    logic [YW-1:0]           r_gy_d1, r_gy_d2;
    logic                    r_hit_d1, r_hit_d2;
    attr_t                   w_attr, r_attr_d2;
    logic [FW-1:0]           r_frame_cnt;
    logic                    r_blink_phase;
    logic [3:0]              r_color, w_color_nxt;
    logic [XW-1:0]           w_bit_idx;
    logic                    w_bit, w_cursor_inv, w_vs_rise;

    vga_console_grid_counter #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .GLYPH_W (GLYPH_W),
        .GLYPH_H (GLYPH_H)
    ) u_grid (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .i_vsync   (in_vsync),
        .i_de      (in_de),
        .o_glyph_x (w_glyph_x),
        .o_glyph_y (w_glyph_y),
        .o_in_grid (w_in_grid),
        .o_address (vga_char_address)
    );

    if (CHAR_BITS == 16) begin : g_attr16
        assign w_attr = '{fg: vga_char[ATTR_FG_LSB +: 4], bg: vga_char[ATTR_BG_LSB +: 4]};
    end else begin : g_attr8
        assign w_attr = '{fg: DEFAULT_FG, bg: DEFAULT_BG};
    end

    assign font_address = {vga_char[7:0], r_gy_d1};

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_pipe <= '0;
            r_vs_pipe <= '0;
            r_de_pipe <= '0;
            r_grid_d1 <= 1'b0;
            r_gx_d1   <= '0;
            r_gy_d1   <= '0;
            r_hit_d1  <= 1'b0;
            r_grid_d2 <= 1'b0;
            r_gx_d2   <= '0;
            r_gy_d2   <= '0;
            r_hit_d2  <= 1'b0;
            r_attr_d2 <= '0;
            r_color   <= '0;
        end else begin
            r_hs_pipe <= {r_hs_pipe[PIPE_LATENCY-2:0], in_hsync};
            r_vs_pipe <= {r_vs_pipe[PIPE_LATENCY-2:0], in_vsync};
            r_de_pipe <= {r_de_pipe[PIPE_LATENCY-2:0], in_de};
            r_grid_d1 <= w_in_grid;
            r_gx_d1   <= w_glyph_x;
            r_gy_d1   <= w_glyph_y;
            r_hit_d1  <= (vga_char_address == cursor_address);
            r_grid_d2 <= r_grid_d1;
            r_gx_d2   <= r_gx_d1;
            r_gy_d2   <= r_gy_d1;
            r_hit_d2  <= r_hit_d1;
            r_attr_d2 <= w_attr;
            r_color   <= w_color_nxt;
        end
    end

    assign w_vs_rise = in_vsync & ~r_vs_pipe[0];

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_vs_rise) begin
            if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                r_frame_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_frame_cnt <= r_frame_cnt + FW'(1);
            end
        end
    end

    // Font ROM data is MSB-first, so pixel 0 of the glyph is the top bit.
    assign w_bit_idx    = XW'(GLYPH_W - 1) - r_gx_d2;
    assign w_bit        = font_row[w_bit_idx];
    assign w_cursor_inv = cursor_enable & r_blink_phase & r_hit_d2
                          & (r_gy_d2 >= YW'(GLYPH_H - 2));

    always_comb begin
        w_color_nxt = 4'h0;
        if (r_de_pipe[PIPE_LATENCY-2] && r_grid_d2) begin
            w_color_nxt = (w_bit ^ w_cursor_inv) ? r_attr_d2.fg : r_attr_d2.bg;
        end
    end

    assign out_hsync = r_hs_pipe[PIPE_LATENCY-1];
    assign out_vsync = r_vs_pipe[PIPE_LATENCY-1];
    assign out_de    = r_de_pipe[PIPE_LATENCY-1];
    assign out_color = r_color;

endmodule
